ycbcr_view_ctrl: RTL and testbench

Frame-synchronous view controller for the RGB→YCbCr converter in the OV5640 video path. It aligns the raw RGB stream with the converter's pipelined YCbCr output and selects one of six display views. View changes requested over a valid/ready config port take effect only at a frame boundary. It also checks each frame's geometry and counts frames.

---
 rtl/ycbcr_view_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ycbcr_view_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_view_ctrl.sv
// ycbcr_view_ctrl
// View controller for the RGB->YCbCr converter output. It lines the raw RGB
// stream up with the converter's delayed samples and picks one of six views.
// View changes are only applied at a frame start. It also checks each frame's
// geometry and counts completed frames.
//
// Config handshake (valid/ready): a request transfers on a rising clock edge
// where cfg_valid && cfg_ready are both high. cfg_mode and cfg_thresh are
// captured on that edge. cfg_ready then stays low until the captured request
// has been applied at a frame start. cfg_valid is ignored while cfg_ready is
// low, and the requester does not need to hold cfg_valid after the transfer.

module ycbcr_view_ctrl #(
  parameter int PIPE_LAT = 4,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rgb_r,
  input  logic [7:0]  rgb_g,
  input  logic [7:0]  rgb_b,
  input  logic        rgb_hs,
  input  logic        rgb_vs,
  input  logic        rgb_de,
  input  logic [7:0]  ycbcr_y,
  input  logic [7:0]  ycbcr_cb,
  input  logic [7:0]  ycbcr_cr,
  input  logic        ycbcr_hs,
  input  logic        ycbcr_vs,
  input  logic        ycbcr_de,
  input  logic [2:0]  cfg_mode,
  input  logic [7:0]  cfg_thresh,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [2:0]  cur_mode,
  output logic [15:0] frame_cnt,
  output logic        frame_err
);

  // View encodings
  localparam logic [2:0] MODE_RGB  = 3'd0;
  localparam logic [2:0] MODE_Y    = 3'd1;
  localparam logic [2:0] MODE_CB   = 3'd2;
  localparam logic [2:0] MODE_CR   = 3'd3;
  localparam logic [2:0] MODE_BIN  = 3'd4;
  localparam logic [2:0] MODE_SKIN = 3'd5;

  // Skin-tone window in the chroma plane, bounds inclusive
  localparam logic [7:0] SKIN_CB_LO = 8'd77;
  localparam logic [7:0] SKIN_CB_HI = 8'd127;
  localparam logic [7:0] SKIN_CR_LO = 8'd133;
  localparam logic [7:0] SKIN_CR_HI = 8'd173;

  // Geometry counter limits and expected sizes at counter width
  localparam logic [11:0] PIX_MAX   = 12'hFFF;
  localparam logic [10:0] LINE_MAX  = 11'h7FF;
  localparam logic [11:0] PIX_EXP   = 12'(H_ACTIVE);
  localparam logic [10:0] LINE_EXP  = 11'(V_ACTIVE);

  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [23:0] rgb_pipe [PIPE_LAT];
  logic [23:0] rgb_al;

  logic        vs_q;
  logic        de_q;
  logic        fs;
  logic        de_fall;

  cfg_state_t  cfg_state;
  logic [2:0]  pend_mode;
  logic [7:0]  pend_thresh;
  logic [7:0]  thresh_q;

  logic [23:0] view_rgb;
  logic        bin_hit;
  logic        skin_hit;

  logic [11:0] pix_cnt;
  logic [10:0] line_cnt;
  logic [10:0] line_eff;
  logic        line_bad;
  logic        line_bad_now;
  logic        armed;

  // The raw sync inputs only document the alignment; they carry no function.
  logic        unused_rgb_sync;
  assign unused_rgb_sync = ^{rgb_hs, rgb_vs, rgb_de};

  // ---------------------------------------------------------------------------
  // RGB delay line: its tail is sample-aligned with the converter output
  // ---------------------------------------------------------------------------
  // Shift raw RGB through PIPE_LAT registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        rgb_pipe[i] <= '0;
      end
    end else begin
      rgb_pipe[0] <= {rgb_r, rgb_g, rgb_b};
      for (int i = 1; i < PIPE_LAT; i++) begin
        rgb_pipe[i] <= rgb_pipe[i-1];
      end
    end
  end

  assign rgb_al = rgb_pipe[PIPE_LAT-1];

  // ---------------------------------------------------------------------------
  // Sync history and edge detection on the converter-side syncs
  // ---------------------------------------------------------------------------
  // Remember last cycle's vs/de for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      vs_q <= ycbcr_vs;
      de_q <= ycbcr_de;
    end
  end

  assign fs      = ycbcr_vs & ~vs_q;
  assign de_fall = de_q & ~ycbcr_de;

  // ---------------------------------------------------------------------------
  // View selection
  // ---------------------------------------------------------------------------
  assign bin_hit  = (ycbcr_y >= thresh_q);
  assign skin_hit = (ycbcr_cb >= SKIN_CB_LO) && (ycbcr_cb <= SKIN_CB_HI) &&
                    (ycbcr_cr >= SKIN_CR_LO) && (ycbcr_cr <= SKIN_CR_HI);

  // Build the displayed pixel for the current view from the aligned sample
  always_comb begin
    view_rgb = 24'h000000;
    case (cur_mode)
      MODE_RGB:  view_rgb = rgb_al;
      MODE_Y:    view_rgb = {ycbcr_y,  ycbcr_y,  ycbcr_y};
      MODE_CB:   view_rgb = {ycbcr_cb, ycbcr_cb, ycbcr_cb};
      MODE_CR:   view_rgb = {ycbcr_cr, ycbcr_cr, ycbcr_cr};
      MODE_BIN:  view_rgb = bin_hit  ? 24'hFFFFFF : 24'h000000;
      MODE_SKIN: view_rgb = skin_hit ? 24'hFFFFFF : 24'h000000;
      default:   view_rgb = 24'h000000;
    endcase
  end

  // Register the output pixel and syncs; blank the pixel outside active video
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r  <= 8'h00;
      out_g  <= 8'h00;
      out_b  <= 8'h00;
      out_hs <= 1'b0;
      out_vs <= 1'b0;
      out_de <= 1'b0;
    end else begin
      if (ycbcr_de) begin
        {out_r, out_g, out_b} <= view_rgb;
      end else begin
        {out_r, out_g, out_b} <= 24'h000000;
      end
      out_hs <= ycbcr_hs;
      out_vs <= ycbcr_vs;
      out_de <= ycbcr_de;
    end
  end

  // ---------------------------------------------------------------------------
  // Config FSM: hold one request and apply it at the next frame start.
  // cfg_ready is the registered image of the IDLE state.
  // ---------------------------------------------------------------------------
  // Accept a request in IDLE, apply it on fs while PENDING
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_state   <= CFG_IDLE;
      cfg_ready   <= 1'b1;
      pend_mode   <= 3'd0;
      pend_thresh <= 8'h00;
      cur_mode    <= MODE_RGB;
      thresh_q    <= 8'h00;
    end else begin
      case (cfg_state)
        CFG_IDLE: begin
          // An fs in the acceptance cycle is deliberately not used here
          if (cfg_valid) begin
            pend_mode   <= cfg_mode;
            pend_thresh <= cfg_thresh;
            cfg_state   <= CFG_PENDING;
            cfg_ready   <= 1'b0;
          end
        end
        CFG_PENDING: begin
          if (fs) begin
            // Undefined view codes fall back to RGB pass-through
            cur_mode  <= (pend_mode > MODE_SKIN) ? MODE_RGB : pend_mode;
            thresh_q  <= pend_thresh;
            cfg_state <= CFG_IDLE;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          cfg_state <= CFG_IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Geometry check
  // ---------------------------------------------------------------------------
  // A line that ends in the fs cycle still belongs to the frame being closed
  assign line_bad_now = de_fall && (pix_cnt != PIX_EXP);
  assign line_eff     = (de_fall && (line_cnt != LINE_MAX)) ? line_cnt + 11'd1
                                                             : line_cnt;

  // Count pixels/lines, latch bad lines and close the frame on fs
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt   <= 12'd0;
      line_cnt  <= 11'd0;
      line_bad  <= 1'b0;
      armed     <= 1'b0;
      frame_cnt <= 16'd0;
      frame_err <= 1'b0;
    end else if (fs) begin
      // The first fs after reset only starts a frame; there is none to close
      armed <= 1'b1;
      if (armed) begin
        frame_cnt <= frame_cnt + 16'd1;
        frame_err <= (line_eff != LINE_EXP) || line_bad || line_bad_now;
      end
      pix_cnt  <= 12'd0;
      line_cnt <= 11'd0;
      line_bad <= 1'b0;
    end else begin
      if (de_fall) begin
        pix_cnt <= 12'd0;
      end else if (ycbcr_de && (pix_cnt != PIX_MAX)) begin
        pix_cnt <= pix_cnt + 12'd1;
      end
      line_cnt <= line_eff;
      if (line_bad_now) begin
        line_bad <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ycbcr_view_ctrl.sv
// Testbench for ycbcr_view_ctrl with small geometry (8x4) and PIPE_LAT=4.
// Expected output pixels come from a small reference model and go through a
// scoreboard queue; control/status outputs are checked inline per scenario.
`timescale 1ns/1ps

module tb_ycbcr_view_ctrl;

  localparam int L = 4;
  localparam int H = 8;
  localparam int V = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic        rgb_hs, rgb_vs, rgb_de;
  logic [7:0]  ycbcr_y, ycbcr_cb, ycbcr_cr;
  logic        ycbcr_hs, ycbcr_vs, ycbcr_de;
  logic [2:0]  cfg_mode;
  logic [7:0]  cfg_thresh;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  out_r, out_g, out_b;
  logic        out_hs, out_vs, out_de;
  logic [2:0]  cur_mode;
  logic [15:0] frame_cnt;
  logic        frame_err;

  ycbcr_view_ctrl #(.PIPE_LAT(L), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .rgb_hs(rgb_hs), .rgb_vs(rgb_vs), .rgb_de(rgb_de),
    .ycbcr_y(ycbcr_y), .ycbcr_cb(ycbcr_cb), .ycbcr_cr(ycbcr_cr),
    .ycbcr_hs(ycbcr_hs), .ycbcr_vs(ycbcr_vs), .ycbcr_de(ycbcr_de),
    .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
    .cur_mode(cur_mode), .frame_cnt(frame_cnt), .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [23:0] m_hist [L];
  logic [2:0]  m_mode;
  logic [7:0]  m_thr;
  bit          m_pend;
  logic [2:0]  m_pmode;
  logic [7:0]  m_pthr;
  logic        m_vs_prev;

  // ---------------------------------------------------------------------------
  // Scoreboard: {hs, vs, de, r, g, b}
  // ---------------------------------------------------------------------------
  logic [26:0] exp_q[$];
  logic [26:0] stage;
  bit          stage_v = 0;
  logic [26:0] mon_e, mon_got;

  always @(posedge clk) begin
    if (stage_v) begin
      exp_q.push_back(stage);
      stage_v = 0;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_got = {out_hs, out_vs, out_de, out_r, out_g, out_b};
      n_checks++;
      if (mon_got !== mon_e) begin
        n_fail++;
        $display("FAIL pixel_out: got %h expected %h at %0t", mon_got, mon_e, $time);
      end
    end
  end

  function automatic logic [23:0] ref_view(input logic [2:0] md, input logic [7:0] thr,
                                           input logic [23:0] rgb, input logic [7:0] y,
                                           input logic [7:0] cb, input logic [7:0] cr);
    logic [23:0] r;
    r = 24'h0;
    if (md == 3'd0) r = rgb;
    else if (md == 3'd1) r = {y, y, y};
    else if (md == 3'd2) r = {cb, cb, cb};
    else if (md == 3'd3) r = {cr, cr, cr};
    else if (md == 3'd4) r = (y >= thr) ? 24'hFFFFFF : 24'h0;
    else if (md == 3'd5)
      r = (cb >= 8'd77 && cb <= 8'd127 && cr >= 8'd133 && cr <= 8'd173) ? 24'hFFFFFF : 24'h0;
    return r;
  endfunction

  function automatic logic [23:0] rnd24();
    return 24'($urandom);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst = 1'b1;
    {rgb_r, rgb_g, rgb_b} = 24'h0;
    {ycbcr_y, ycbcr_cb, ycbcr_cr} = 24'h0;
    ycbcr_hs = 0; ycbcr_vs = 0; ycbcr_de = 0;
    cfg_valid = 0; cfg_mode = 0; cfg_thresh = 0;
    for (int i = 0; i < L; i++) m_hist[i] = 24'h0;
    m_mode = 0; m_thr = 0; m_pend = 0; m_pmode = 0; m_pthr = 0; m_vs_prev = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  // One clock of stimulus; returns 1ns after the edge that consumed it
  task automatic cyc(input logic [23:0] rgb, input logic [23:0] ycc, input logic vs,
                     input logic de, input logic cv, input logic [2:0] cm,
                     input logic [7:0] ct);
    logic [23:0] aligned;
    logic        fs;
    {rgb_r, rgb_g, rgb_b} = rgb;
    {ycbcr_y, ycbcr_cb, ycbcr_cr} = ycc;
    ycbcr_hs = 1'b0; ycbcr_vs = vs; ycbcr_de = de;
    cfg_valid = cv; cfg_mode = cm; cfg_thresh = ct;
    aligned = m_hist[L-1];
    stage = {1'b0, vs, de,
             de ? ref_view(m_mode, m_thr, aligned, ycc[23:16], ycc[15:8], ycc[7:0]) : 24'h0};
    stage_v = 1;
    for (int i = L - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = rgb;
    fs = vs & ~m_vs_prev;
    m_vs_prev = vs;
    if (m_pend) begin
      if (fs) begin
        m_mode = (m_pmode > 3'd5) ? 3'd0 : m_pmode;
        m_thr  = m_pthr;
        m_pend = 0;
      end
    end else if (cv) begin
      m_pmode = cm; m_pthr = ct; m_pend = 1;
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic pix(input logic [23:0] rgb, input logic [23:0] ycc);
    cyc(rgb, ycc, 1'b0, 1'b1, 1'b0, 3'd0, 8'h0);
  endtask

  task automatic request(input logic [2:0] md, input logic [7:0] thr);
    cyc(rnd24(), rnd24(), 1'b0, 1'b0, 1'b1, md, thr);
  endtask

  task automatic frame_start();
    cyc(rnd24(), rnd24(), 1'b1, 1'b0, 1'b0, 3'd0, 8'h0);
    cyc(rnd24(), rnd24(), 1'b1, 1'b0, 1'b0, 3'd0, 8'h0);
    cyc(rnd24(), rnd24(), 1'b0, 1'b0, 1'b0, 3'd0, 8'h0);
  endtask

  task automatic lines(input int n, input int short_idx, input bit trail);
    int np;
    for (int l = 0; l < n; l++) begin
      np = (l == short_idx) ? H - 1 : H;
      for (int p = 0; p < np; p++) pix(rnd24(), rnd24());
      if (l < n - 1 || trail) cyc(rnd24(), rnd24(), 1'b0, 1'b0, 1'b0, 3'd0, 8'h0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_hs, out_vs, out_de, out_r, out_g, out_b} !== 27'h0) begin
      n_fail++; $display("FAIL reset_out: got %h expected 0", {out_hs, out_vs, out_de, out_r, out_g, out_b});
    end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    n_checks++;
    if (cur_mode !== 3'd0) begin n_fail++; $display("FAIL reset_cur_mode: got %0d expected 0", cur_mode); end
    n_checks++;
    if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_frame_cnt: got %h expected 0", frame_cnt); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
  endtask

  task automatic test_align();
    for (int i = 0; i < L + 3; i++) pix(24'h0A141E, 24'h28323C);
    for (int i = 0; i < 8; i++) pix(rnd24(), rnd24());
    for (int i = 0; i < 3; i++) cyc(rnd24(), rnd24(), 1'b0, 1'b0, 1'b0, 3'd0, 8'h0);
    for (int i = 0; i < 6; i++) pix(rnd24(), rnd24());
  endtask

  task automatic test_mode_switch();
    frame_start();
    lines(2, -1, 1'b1);
    cyc(rnd24(), rnd24(), 1'b0, 1'b1, 1'b1, 3'd1, 8'h00);
    n_checks++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL switch_ready_drop: got %b expected 0", cfg_ready); end
    for (int i = 0; i < 5; i++) pix(rnd24(), rnd24());
    n_checks++;
    if (cur_mode !== 3'd0) begin n_fail++; $display("FAIL switch_mode_hold: got %0d expected 0", cur_mode); end
    // fs cycle carries an active pixel that must still be shown as RGB
    cyc(rnd24(), rnd24(), 1'b1, 1'b1, 1'b0, 3'd0, 8'h0);
    n_checks++;
    if (cur_mode !== 3'd1) begin n_fail++; $display("FAIL switch_mode_apply: got %0d expected 1", cur_mode); end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL switch_ready_rise: got %b expected 1", cfg_ready); end
    cyc(rnd24(), rnd24(), 1'b0, 1'b0, 1'b0, 3'd0, 8'h0);
    lines(2, -1, 1'b1);
  endtask

  task automatic test_binary();
    logic [7:0] ys [5] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h81};
    request(3'd4, 8'h80);
    frame_start();
    n_checks++;
    if (cur_mode !== 3'd4) begin n_fail++; $display("FAIL binary_mode: got %0d expected 4", cur_mode); end
    for (int i = 0; i < 5; i++) pix(rnd24(), {ys[i], 16'($urandom)});
    lines(1, -1, 1'b1);
  endtask

  task automatic test_skin();
    logic [7:0] cbs [6] = '{8'd77, 8'd76, 8'd127, 8'd127, 8'd128, 8'd100};
    logic [7:0] crs [6] = '{8'd133, 8'd133, 8'd174, 8'd173, 8'd150, 8'd132};
    request(3'd5, 8'h00);
    frame_start();
    n_checks++;
    if (cur_mode !== 3'd5) begin n_fail++; $display("FAIL skin_mode: got %0d expected 5", cur_mode); end
    for (int i = 0; i < 6; i++) pix(rnd24(), {8'($urandom), cbs[i], crs[i]});
    lines(1, -1, 1'b1);
  endtask

  task automatic test_pending();
    request(3'd2, 8'h00);
    request(3'd3, 8'h10);
    n_checks++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL pend_ready: got %b expected 0", cfg_ready); end
    frame_start();
    n_checks++;
    if (cur_mode !== 3'd2) begin n_fail++; $display("FAIL pend_ignored: got %0d expected 2", cur_mode); end
    lines(1, -1, 1'b1);
    // Request accepted in the same cycle as fs
    cyc(rnd24(), rnd24(), 1'b1, 1'b0, 1'b1, 3'd3, 8'h20);
    n_checks++;
    if (cur_mode !== 3'd2) begin n_fail++; $display("FAIL same_fs_hold: got %0d expected 2", cur_mode); end
    n_checks++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL same_fs_ready: got %b expected 0", cfg_ready); end
    cyc(rnd24(), rnd24(), 1'b0, 1'b0, 1'b0, 3'd0, 8'h0);
    lines(1, -1, 1'b1);
    frame_start();
    n_checks++;
    if (cur_mode !== 3'd3) begin n_fail++; $display("FAIL same_fs_next: got %0d expected 3", cur_mode); end
    lines(1, -1, 1'b1);
    request(3'd6, 8'h55);
    frame_start();
    n_checks++;
    if (cur_mode !== 3'd0) begin n_fail++; $display("FAIL mode6_store: got %0d expected 0", cur_mode); end
    lines(1, -1, 1'b1);
  endtask

  task automatic check_frame(input string name, input logic [15:0] cnt, input logic err);
    n_checks++;
    if (frame_cnt !== cnt) begin n_fail++; $display("FAIL %s_cnt: got %h expected %h", name, frame_cnt, cnt); end
    n_checks++;
    if (frame_err !== err) begin n_fail++; $display("FAIL %s_err: got %b expected %b", name, frame_err, err); end
  endtask

  task automatic test_geometry();
    do_reset();
    frame_start();
    check_frame("geo_first", 16'd0, 1'b0);
    lines(4, -1, 1'b1);
    frame_start();
    check_frame("geo_good", 16'd1, 1'b0);
    lines(4, 1, 1'b1);
    frame_start();
    check_frame("geo_short_line", 16'd2, 1'b1);
    lines(5, -1, 1'b1);
    frame_start();
    check_frame("geo_five_lines", 16'd3, 1'b1);
    lines(4, -1, 1'b1);
    frame_start();
    check_frame("geo_recover", 16'd4, 1'b0);
    lines(4, 3, 1'b0);
    frame_start();
    check_frame("geo_short_at_fs", 16'd5, 1'b1);
    lines(4, -1, 1'b0);
    frame_start();
    check_frame("geo_good_at_fs", 16'd6, 1'b0);
  endtask

  task automatic test_wrap();
    force dut.frame_cnt = 16'hFFFF;
    cyc(rnd24(), rnd24(), 1'b0, 1'b0, 1'b0, 3'd0, 8'h0);
    release dut.frame_cnt;
    cyc(rnd24(), rnd24(), 1'b0, 1'b0, 1'b0, 3'd0, 8'h0);
    n_checks++;
    if (frame_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preset: got %h expected ffff", frame_cnt); end
    lines(4, -1, 1'b1);
    frame_start();
    check_frame("wrap", 16'h0000, 1'b0);
  endtask

  task automatic test_reset_mid();
    request(3'd3, 8'h00);
    lines(3, -1, 1'b1);
    frame_start();
    check_frame("pre_rst", 16'h0001, 1'b1);
    for (int i = 0; i < 4; i++) pix(rnd24(), rnd24());
    do_reset();
    n_checks++;
    if ({out_hs, out_vs, out_de, out_r, out_g, out_b} !== 27'h0) begin
      n_fail++; $display("FAIL mid_rst_out: got %h expected 0", {out_hs, out_vs, out_de, out_r, out_g, out_b});
    end
    n_checks++;
    if (cur_mode !== 3'd0) begin n_fail++; $display("FAIL mid_rst_mode: got %0d expected 0", cur_mode); end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", cfg_ready); end
    check_frame("mid_rst", 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) pix(rnd24(), rnd24());
    frame_start();
    check_frame("after_rst_first_fs", 16'h0000, 1'b0);
    lines(3, -1, 1'b1);
    frame_start();
    check_frame("after_rst_second_fs", 16'h0001, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    rgb_hs = 0; rgb_vs = 0; rgb_de = 0;
    test_reset();
    test_align();
    test_mode_switch();
    test_binary();
    test_skin();
    test_pending();
    test_geometry();
    test_wrap();
    test_reset_mid();
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
